// File: rtl/opb_simulink_pkg.sv
// Shared definitions for the simulink<->PPC OPB register blocks:
// register offsets, STATUS layout and the ack FSM encoding.
package opb_simulink_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int STAT_VALID = 31;
    localparam int STAT_OVF   = 30;
    localparam int STAT_FRZ   = 29;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } ack_state_e;

    function automatic logic [31:0] status_word(
        input logic             valid,
        input logic             ovf,
        input logic             frz,
        input logic [CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w             = '0;
        w[STAT_VALID] = valid;
        w[STAT_OVF]   = ovf;
        w[STAT_FRZ]   = frz;
        w[CNT_W-1:0]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB hit decode and single-ack FSM; latches direction and word
// offset of the accepted transfer for use during the ack cycle.
module opb_slave_ack_fsm
    import opb_simulink_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h01000900,
    parameter logic [31:0] C_HIGHADDR = 32'h010009FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        select_i,
    input  logic [31:0] addr_i,
    input  logic        rnw_i,
    output logic        ack_o,
    output logic        load_o,
    output logic        rnw_o,
    output logic [1:0]  off_o
);

    ack_state_e state_q, state_d;
    logic       rnw_q, rnw_d;
    logic [1:0] off_q, off_d;
    logic       hit;

    assign hit = select_i
              && (addr_i >= C_BASEADDR)
              && (addr_i <= C_HIGHADDR);

    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        off_d   = off_q;
        load_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_ACK;
                    rnw_d   = rnw_i;
                    off_d   = addr_i[3:2];
                    load_o  = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_HOLD;
            // wait for the master to release select so one transfer gets one ack
            ST_HOLD: if (!select_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rnw_q   <= 1'b0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rnw_q   <= rnw_d;
            off_q   <= off_d;
        end
    end

    assign ack_o = (state_q == ST_ACK);
    assign rnw_o = rnw_q;
    assign off_o = off_q;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave snapshot register: captures a fabric word on each strobe and
// exposes it with status (valid/overflow/count) and a freeze control.
module opb_register_simulink2ppc_snap
    import opb_simulink_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01000900,
    parameter logic [31:0] C_HIGHADDR   = 32'h010009FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid
);

    localparam bit unused_family = (C_FAMILY != "");

    logic             ack, load, acc_rnw;
    logic [1:0]       acc_off;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             frz_q, frz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dbus_q, dbus_d;
    logic [31:0]      rd_word;
    logic             capture, rd_clr, ctrl_wr;
    logic             unused_ok;

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .clk      (OPB_Clk),
        .rst_n    (OPB_Rst),
        .select_i (OPB_select),
        .addr_i   (OPB_ABus),
        .rnw_i    (OPB_RNW),
        .ack_o    (ack),
        .load_o   (load),
        .rnw_o    (acc_rnw),
        .off_o    (acc_off)
    );

    always_comb begin
        rd_word = '0;
        case (OPB_ABus[28:29])
            OFF_DATA:   rd_word = data_q;
            OFF_STATUS: rd_word = status_word(valid_q, ovf_q, frz_q, cnt_q);
            OFF_CTRL:   rd_word = {31'd0, frz_q};
            default:    rd_word = '0;
        endcase
    end

    assign capture = user_data_valid && !frz_q;
    assign rd_clr  = ack && acc_rnw && (acc_off == OFF_DATA);
    assign ctrl_wr = ack && !acc_rnw && (acc_off == OFF_CTRL);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        frz_d   = frz_q;
        cnt_d   = cnt_q;
        dbus_d  = (load && OPB_RNW) ? rd_word : 32'd0;
        if (rd_clr) valid_d = 1'b0;
        if (capture) begin
            data_d  = user_data_in;
            valid_d = 1'b1;
            // a word consumed by this same read is not an overflow
            if (valid_q && !rd_clr) ovf_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
        if (ctrl_wr) begin
            ovf_d = 1'b0;
            cnt_d = capture ? CNT_W'(1) : '0;
            if (OPB_BE[3]) frz_d = OPB_DBus[31];
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            frz_q   <= 1'b0;
            cnt_q   <= '0;
            dbus_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            frz_q   <= frz_d;
            cnt_q   <= cnt_d;
            dbus_q  <= dbus_d;
        end
    end

    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:30]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Bench for the OPB snapshot register: vector table of OPB reads/writes
// and strobes, plus hand sequences for the simultaneous-event corners.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] A_DATA = 32'h01000900;
    localparam logic [31:0] A_STAT = 32'h01000904;
    localparam logic [31:0] A_CTRL = 32'h01000908;
    localparam logic [31:0] A_RSV  = 32'h0100090C;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_data_valid;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk         (OPB_Clk),
        .OPB_Rst         (OPB_Rst),
        .OPB_ABus        (OPB_ABus),
        .OPB_BE          (OPB_BE),
        .OPB_DBus        (OPB_DBus),
        .OPB_RNW         (OPB_RNW),
        .OPB_select      (OPB_select),
        .OPB_seqAddr     (OPB_seqAddr),
        .Sl_DBus         (Sl_DBus),
        .Sl_xferAck      (Sl_xferAck),
        .Sl_errAck       (Sl_errAck),
        .Sl_retry        (Sl_retry),
        .Sl_toutSup      (Sl_toutSup),
        .user_data_in    (user_data_in),
        .user_data_valid (user_data_valid)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    typedef enum {OP_S, OP_R, OP_W, OP_MR, OP_MW} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       nm;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ack_cnt = 0;

    function automatic vec_t V(op_e op, logic [31:0] addr, logic [31:0] d,
                               logic [3:0] be, logic [31:0] exp, string nm);
        vec_t v;
        v.op = op; v.addr = addr; v.d = d; v.be = be; v.exp = exp; v.nm = nm;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic step();
        sb_t e;
        @(negedge OPB_Clk);
        if (Sl_xferAck) begin
            ack_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(Sl_xferAck), 32'd0);
            end else begin
                e = sb.pop_front();
                check(e.nm, Sl_DBus, e.exp);
            end
        end else begin
            check("dbus_idle", Sl_DBus, 32'd0);
        end
    endtask

    task automatic bus_idle();
        OPB_select = 1'b0;
        OPB_ABus   = '0;
        OPB_RNW    = 1'b0;
        OPB_DBus   = '0;
        OPB_BE     = '0;
    endtask

    task automatic strobe(logic [31:0] d);
        user_data_valid = 1'b1;
        user_data_in    = d;
        step();
        user_data_valid = 1'b0;
        user_data_in    = '0;
    endtask

    task automatic opb(bit rnw, logic [31:0] addr, logic [31:0] wd,
                       logic [3:0] be, bit hit, logic [31:0] exp, string nm,
                       bit astrb = 1'b0, logic [31:0] adata = '0);
        int a0;
        int k;
        a0 = ack_cnt;
        OPB_select = 1'b1;
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_DBus   = wd;
        OPB_BE     = be;
        if (hit) begin
            sb.push_back('{exp: (rnw ? exp : 32'd0), nm: nm});
            k = 0;
            while (ack_cnt == a0 && k < 8) begin
                step();
                k++;
            end
            check({nm, "_ack"}, 32'(ack_cnt - a0), 32'd1);
            if (ack_cnt == a0) sb.delete();
            if (astrb) begin
                user_data_valid = 1'b1;
                user_data_in    = adata;
            end
            step();
            user_data_valid = 1'b0;
            bus_idle();
            step();
            step();
        end else begin
            repeat (4) step();
            check(nm, 32'(ack_cnt - a0), 32'd0);
            bus_idle();
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        OPB_Rst         = 1'b0;
        OPB_seqAddr     = 1'b0;
        user_data_in    = '0;
        user_data_valid = 1'b0;
        bus_idle();

        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'h00000000, "rst_status"));
        tbl.push_back(V(OP_R,  A_DATA, 0, 4'hF, 32'h00000000, "rst_data"));
        tbl.push_back(V(OP_R,  A_CTRL, 0, 4'hF, 32'h00000000, "rst_ctrl"));
        tbl.push_back(V(OP_S,  0, 32'hDEADBEEF, 0, 0, "s_dead"));
        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'h80000001, "st_new"));
        tbl.push_back(V(OP_R,  A_DATA, 0, 4'hF, 32'hDEADBEEF, "data_dead"));
        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'h00000001, "st_read"));
        tbl.push_back(V(OP_W,  A_CTRL, 0, 4'hF, 0, "w_clr"));
        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'h00000000, "st_clr"));
        tbl.push_back(V(OP_S,  0, 32'h11, 0, 0, "s_11"));
        tbl.push_back(V(OP_S,  0, 32'h22, 0, 0, "s_22"));
        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'hC0000002, "st_ovf"));
        tbl.push_back(V(OP_R,  A_DATA, 0, 4'hF, 32'h00000022, "data_22"));
        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'h40000002, "st_ovf_rd"));
        tbl.push_back(V(OP_W,  A_CTRL, 1, 4'hF, 0, "w_frz"));
        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'h20000000, "st_frz"));
        tbl.push_back(V(OP_S,  0, 32'h33, 0, 0, "s_33"));
        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'h20000000, "st_frz_ign"));
        tbl.push_back(V(OP_R,  A_DATA, 0, 4'hF, 32'h00000022, "data_frz"));
        tbl.push_back(V(OP_R,  A_CTRL, 0, 4'hF, 32'h00000001, "ctrl_1"));
        tbl.push_back(V(OP_W,  A_CTRL, 0, 4'h0, 0, "w_be0"));
        tbl.push_back(V(OP_R,  A_CTRL, 0, 4'hF, 32'h00000001, "ctrl_be0"));
        tbl.push_back(V(OP_W,  A_CTRL, 0, 4'h1, 0, "w_be3"));
        tbl.push_back(V(OP_R,  A_CTRL, 0, 4'hF, 32'h00000000, "ctrl_be3"));
        tbl.push_back(V(OP_S,  0, 32'h44, 0, 0, "s_44"));
        tbl.push_back(V(OP_W,  A_STAT, 32'hFFFFFFFF, 4'hF, 0, "w_stat"));
        tbl.push_back(V(OP_W,  A_DATA, 32'h12345678, 4'hF, 0, "w_data"));
        tbl.push_back(V(OP_W,  A_RSV,  32'hFFFFFFFF, 4'hF, 0, "w_rsv"));
        tbl.push_back(V(OP_R,  A_RSV,  0, 4'hF, 32'h00000000, "rsv_rd"));
        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'h80000001, "st_44"));
        tbl.push_back(V(OP_R,  A_DATA, 0, 4'hF, 32'h00000044, "data_44"));
        tbl.push_back(V(OP_MR, 32'h01000A00, 0, 4'hF, 0, "miss_hi"));
        tbl.push_back(V(OP_MR, 32'h010008FC, 0, 4'hF, 0, "miss_lo"));
        tbl.push_back(V(OP_MW, 32'h01000A08, 1, 4'hF, 0, "miss_wr"));
        tbl.push_back(V(OP_R,  A_CTRL, 0, 4'hF, 32'h00000000, "ctrl_miss"));
        tbl.push_back(V(OP_S,  0, 32'h55, 0, 0, "s_55"));
        tbl.push_back(V(OP_W,  A_CTRL, 0, 4'hF, 0, "w_clr2"));
        tbl.push_back(V(OP_R,  A_STAT, 0, 4'hF, 32'h80000000, "st_clr_v"));
        tbl.push_back(V(OP_R,  32'h010009FC, 0, 4'hF, 32'h00000000, "top_rsv"));
        tbl.push_back(V(OP_R,  32'h010009F4, 0, 4'hF, 32'h80000000, "top_stat"));

        repeat (3) step();
        check("rst_ack", 32'(Sl_xferAck), 32'd0);
        check("rst_dbus", Sl_DBus, 32'd0);
        OPB_Rst = 1'b1;
        step();

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_S:  strobe(tbl[i].d);
                OP_R:  opb(1'b1, tbl[i].addr, 0, tbl[i].be, 1'b1,
                           tbl[i].exp, tbl[i].nm);
                OP_W:  opb(1'b0, tbl[i].addr, tbl[i].d, tbl[i].be, 1'b1,
                           0, tbl[i].nm);
                OP_MR: opb(1'b1, tbl[i].addr, 0, tbl[i].be, 1'b0,
                           0, tbl[i].nm);
                OP_MW: opb(1'b0, tbl[i].addr, tbl[i].d, tbl[i].be, 1'b0,
                           0, tbl[i].nm);
                default: ;
            endcase
        end

        // select held high for several cycles: one ack only
        a0 = ack_cnt;
        OPB_select = 1'b1;
        OPB_ABus   = A_STAT;
        OPB_RNW    = 1'b1;
        sb.push_back('{exp: 32'h80000000, nm: "hold_st"});
        repeat (6) step();
        check("hold_one_ack", 32'(ack_cnt - a0), 32'd1);
        sb.delete();
        bus_idle();
        step();
        step();

        // strobe during a DATA-read ack: old word returned, valid kept
        opb(1'b1, A_DATA, 0, 4'hF, 1'b1, 32'h00000055, "rd_race",
            1'b1, 32'h77);
        opb(1'b1, A_STAT, 0, 4'hF, 1'b1, 32'h80000001, "st_race");
        opb(1'b1, A_DATA, 0, 4'hF, 1'b1, 32'h00000077, "data_77");

        // strobe during a CTRL-write clear: overflow cleared, count 1
        strobe(32'h88);
        strobe(32'h99);
        opb(1'b1, A_STAT, 0, 4'hF, 1'b1, 32'hC0000003, "st_pre_wr");
        opb(1'b0, A_CTRL, 0, 4'hF, 1'b1, 0, "wr_race", 1'b1, 32'hAA);
        opb(1'b1, A_STAT, 0, 4'hF, 1'b1, 32'h80000001, "st_wr_race");
        opb(1'b1, A_DATA, 0, 4'hF, 1'b1, 32'h000000AA, "data_aa");

        // asynchronous reset while the ack is pending
        opb(1'b0, A_CTRL, 1, 4'hF, 1'b1, 0, "w_frz2");
        a0 = ack_cnt;
        OPB_select = 1'b1;
        OPB_ABus   = A_DATA;
        OPB_RNW    = 1'b1;
        @(posedge OPB_Clk);
        #1 OPB_Rst = 1'b0;
        step();
        check("rst_mid_ack", 32'(Sl_xferAck), 32'd0);
        bus_idle();
        step();
        step();
        OPB_Rst = 1'b1;
        repeat (3) step();
        check("rst_no_ack", 32'(ack_cnt - a0), 32'd0);
        opb(1'b1, A_STAT, 0, 4'hF, 1'b1, 32'h00000000, "rst2_status");
        opb(1'b1, A_DATA, 0, 4'hF, 1'b1, 32'h00000000, "rst2_data");
        opb(1'b1, A_CTRL, 0, 4'hF, 1'b1, 32'h00000000, "rst2_ctrl");

        check("tied_outs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
Name: opb_register_simulink2ppc_snap

Overview:
- OPB slave that carries a 32-bit word from user fabric to the PowerPC: the reverse path of a ppc2simulink register.
- Captures user_data_in on each user_data_valid strobe and holds it for OPB reads.
- Provides a status word (new-data flag, overflow flag, capture count) and a control word (freeze).
- Single clock domain. User logic is synchronous to OPB_Clk; no CDC inside this block.

Parameters:
- C_BASEADDR, 32'h01000900, first byte address of the 256-byte window
- C_HIGHADDR, 32'h010009FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width (only 32 supported)
- C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
- C_FAMILY, "virtex5", target family string; no functional effect

Ports:
- OPB_Clk  in  1  sole clock
- OPB_Rst  in  1  asynchronous, active-low reset (low = reset)
- OPB_ABus  in  [0:31]  OPB address, bit 0 = MSB
- OPB_BE  in  [0:3]  byte enables; BE[3] = bits 7:0
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  master select
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; zero except during read ack
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck  out  1  tied 0
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- user_data_in  in  [31:0]  fabric word
- user_data_valid  in  1  capture strobe, one cycle per word

Behaviour:
- Bit n below means LSB-numbered bit n, i.e. Sl_DBus[31-n].
- Register map, word offset = OPB_ABus[28:29]:
  - 0 DATA (RO): last captured word.
  - 1 STATUS (RO): bit31 valid, bit30 overflow, bit29 freeze echo, bits 15:0 capture count; other bits 0.
  - 2 CTRL (RW): bit0 freeze. A write to CTRL with BE[0]... BE[3] set updates freeze. Any write to CTRL, regardless of BE, clears overflow and count.
  - 3 reserved: reads 0, writes ignored.
- Hit condition: OPB_select = 1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Slave FSM:
  - IDLE: on hit, go to ACK.
  - ACK: Sl_xferAck = 1 for exactly one cycle; on a read, Sl_DBus = selected register; a write takes effect at the end of this cycle. Go to HOLD.
  - HOLD: stay while OPB_select = 1; go to IDLE when OPB_select = 0. This prevents a double ack.
  - Ack latency is 1 cycle after select/address are sampled.
- Read data is the register value sampled at the IDLE->ACK edge. DATA, STATUS and CTRL are all registered.
- Capture, when user_data_valid = 1 and freeze = 0:
  - DATA <= user_data_in and valid <= 1.
  - count += 1, saturating at 16'hFFFF.
  - If valid was already 1, overflow <= 1. Latest data wins.
- When freeze = 1: strobes are ignored entirely (no DATA, count or overflow change).
- Reading DATA clears valid at the end of the ACK cycle.
- Simultaneous events:
  - Capture in the same cycle as the DATA-read clear: capture wins, valid stays 1, overflow unchanged. The OPB returns the old data.
  - Capture in the same cycle as the CTRL-write clear: the clear wins for overflow; count = 1 if the capture was accepted, else 0.
- Writes to DATA, STATUS or reserved offsets are acked and ignored.
- Reset (OPB_Rst = 0, asynchronous, at any time including mid-transfer):
  - FSM to IDLE; Sl_xferAck = 0; Sl_DBus = 0.
  - DATA = 0, valid = 0, overflow = 0, count = 0, freeze = 0.
  - A transfer in flight at reset is not acked; the master times out.

Decomposition:
- Shared package opb_simulink_pkg:
  - register offset constants (DATA = 0, STATUS = 1, CTRL = 2)
  - STATUS bit positions
  - FSM state encoding (IDLE, ACK, HOLD)
- Sub-module opb_slave_ack_fsm: hit decode plus the three-state ack FSM; outputs a one-cycle ack and latched rnw/offset.
- The register bank and capture logic stay in the top module.

Test Plan:
- Reset, then read STATUS at 0x01000904 -> Sl_xferAck high for exactly 1 cycle, Sl_DBus = 0x00000000; Sl_DBus = 0 on every other cycle.
- Strobe 0xDEADBEEF, then read DATA -> 0xDEADBEEF. STATUS read before the DATA read = 0x80000001; after it = 0x00000001.
- Strobe 0x11, then 0x22 with no read, then read STATUS and DATA -> STATUS = 0xC0000002, DATA = 0x22.
- Write CTRL = 0x1 (BE = 1111), strobe 0x33 -> DATA unchanged, count unchanged, STATUS bit29 = 1. Write CTRL = 0x0 -> overflow and count cleared, STATUS = 0x80000000 if valid was set.
- Hold OPB_select high for 5 cycles on a hit -> exactly one ack. An address of 0x01000A00 -> no ack.
- Assert OPB_Rst low in the ACK-pending cycle -> no ack, all registers zero. A strobe on the same cycle as a DATA-read ack -> the read returns the old word, valid stays 1.
